// File: rtl/lab_pkg.sv
// Shared types and constants for the execute-stage multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lab_pkg;

  // Default operand/result width of the iterative multiplier (N).
  localparam int MUL_N = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mulseq_state_t;

endpackage

// File: rtl/mul_iter_dp.sv
// Shift-add multiplier datapath: accumulator, shifting operands, iteration counter.
// Latency: one iteration per step; N steps give the low N bits of the product.
// Backpressure: none; the controller decides when to load and step.
module mul_iter_dp #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] mcand_in,
  input  logic [N-1:0] mplier_in,
  output logic [N-1:0] acc,
  output logic         last
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [CW-1:0] count;

  // Load operands on acceptance, then one conditional add and shift per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      count  <= '0;
    end else if (step) begin
      // Carries past bit N-1 fall off: only the low N product bits matter.
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  // The step taken while this is high is the final iteration.
  assign last = (count == CW'(N - 1));

endmodule

// File: rtl/exec_mul_seq.sv
// Multi-cycle MUL sequencer beside execute: stalls the front end, iterates, presents the product.
// Latency: accept cycle + N RUN cycles + 1 DONE cycle; stall_o high for N+1 cycles.
// Backpressure: stall_o freezes PC, IF/ID and ID/EX; flush_E aborts, reset aborts without done.
module exec_mul_seq
  import lab_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_E,
  input  logic         flush_E,
  input  logic [N-1:0] srcA_E,
  input  logic [N-1:0] srcB_E,
  output logic         stall_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] mulResult_o
);

  mulseq_state_t state;
  logic [N-1:0]  acc;
  logic [N-1:0]  res_q;
  logic          last;
  logic          load;
  logic          step;

  // Operands are captured only here; later changes on srcA_E/srcB_E are ignored.
  assign load = (state == IDLE) && start_E && !flush_E;
  assign step = (state == RUN) && !flush_E;

  mul_iter_dp #(.N(N)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .mcand_in  (srcA_E),
    .mplier_in (srcB_E),
    .acc       (acc),
    .last      (last)
  );

  // Sequencer state plus the held copy of the last delivered product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (load) state <= RUN;
        RUN: begin
          if (flush_E)   state <= IDLE;
          else if (last) state <= DONE;
        end
        DONE: begin
          // start_E still shows the MUL that is just leaving, so never re-accept here.
          state <= IDLE;
          if (!flush_E) res_q <= acc;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state == RUN);
  // A killed instruction must not hand its result to writeback.
  assign done_o      = (state == DONE) && !flush_E;
  assign mulResult_o = done_o ? acc : res_q;

  // Stall depends only on state, start_E and flush_E so it never waits on the datapath.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:    stall_o = start_E && !flush_E;
      RUN:     stall_o = !flush_E;
      default: stall_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exec_mul_seq.sv
module tb_exec_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_E = 1'b0;
  logic        flush_E = 1'b0;
  logic [63:0] srcA_E = '0;
  logic [63:0] srcB_E = '0;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [63:0] mulResult_o;

  int errors = 0;
  int checks = 0;

  exec_mul_seq #(.N(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_E     (start_E),
    .flush_E     (flush_E),
    .srcA_E      (srcA_E),
    .srcB_E      (srcB_E),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mulResult_o (mulResult_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge. Holds start_E until done_o, scrambles the
  // operand inputs after acceptance, and returns just after the edge that ends DONE.
  task automatic do_mul(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input string nm, input bit tail);
    int cyc = 0;
    int stalls = 0;
    bit seen = 0;
    srcA_E  = a;
    srcB_E  = b;
    start_E = 1'b1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        srcA_E = ~a;
        srcB_E = b ^ 64'h5A5A;
      end
      if (done_o) begin
        seen = 1;
        chk({nm, " result"}, mulResult_o, exp);
        chk({nm, " done cycle"}, 64'(cyc), 64'd66);
        chk({nm, " stall cycles"}, 64'(stalls), 64'd65);
        chk({nm, " stall in DONE"}, 64'(stall_o), 64'd0);
      end else if (stall_o) begin
        stalls++;
      end
    end
    if (!seen) chk({nm, " done seen"}, 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    start_E = 1'b0;
    if (tail) begin
      @(negedge clk);
      chk({nm, " done width"}, 64'(done_o), 64'd0);
      chk({nm, " stall after"}, 64'(stall_o), 64'd0);
      chk({nm, " result held"}, mulResult_o, exp);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int saw_done;

    vecs[0] = '{64'd7, 64'd6, 64'd42, "7x6"};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, "neg1x3"};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0, "2p63x2"};
    vecs[3] = '{64'h1234, 64'd0, 64'd0, "zero_mplier"};
    vecs[4] = '{64'h1_0000_0001, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "2p32pm1"};
    vecs[5] = '{64'd12345, 64'd6789, 64'd83810205, "12345x6789"};

    // Reset asserted mid-cycle, then idle with start_E low.
    #2 reset = 1'b1;
    #1;
    chk("rst stall", 64'(stall_o), 64'd0);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst done", 64'(done_o), 64'd0);
    chk("rst result", mulResult_o, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle stall", 64'(stall_o), 64'd0);
      chk("idle busy", 64'(busy_o), 64'd0);
      chk("idle done", 64'(done_o), 64'd0);
      chk("idle result", mulResult_o, 64'd0);
    end
    @(posedge clk);
    #1;

    // Table-driven multiplies.
    for (int i = 0; i < 6; i++) begin
      do_mul(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm, 1'b1);
    end

    // Back-to-back: the second start is presented straight after DONE.
    do_mul(64'd5, 64'd5, 64'd25, "b2b first", 1'b0);
    do_mul(64'd9, 64'd11, 64'd99, "b2b second", 1'b1);

    // Flush at RUN cycle 10.
    srcA_E  = 64'd100;
    srcB_E  = 64'd3;
    start_E = 1'b1;
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;
    chk("flush busy before", 64'(busy_o), 64'd1);
    flush_E = 1'b1;
    start_E = 1'b0;
    #1;
    chk("flush stall comb", 64'(stall_o), 64'd0);
    chk("flush done comb", 64'(done_o), 64'd0);
    @(posedge clk);
    #1;
    flush_E = 1'b0;
    chk("flush idle busy", 64'(busy_o), 64'd0);
    chk("flush idle stall", 64'(stall_o), 64'd0);
    chk("flush result kept", mulResult_o, 64'd99);
    saw_done = 0;
    repeat (70) begin
      @(negedge clk);
      if (done_o) saw_done = 1;
    end
    chk("flush no done", 64'(saw_done), 64'd0);
    chk("flush result later", mulResult_o, 64'd99);
    @(posedge clk);
    #1;

    // Asynchronous reset at RUN cycle 30.
    srcA_E  = 64'd100;
    srcB_E  = 64'd3;
    start_E = 1'b1;
    @(posedge clk);
    #1;
    repeat (29) @(posedge clk);
    #1;
    chk("areset busy before", 64'(busy_o), 64'd1);
    #2;
    reset   = 1'b1;
    start_E = 1'b0;
    #1;
    chk("areset stall", 64'(stall_o), 64'd0);
    chk("areset busy", 64'(busy_o), 64'd0);
    chk("areset done", 64'(done_o), 64'd0);
    chk("areset result", mulResult_o, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    repeat (70) begin
      @(negedge clk);
      if (done_o) saw_done = 1;
    end
    chk("areset no done", 64'(saw_done), 64'd0);
    @(posedge clk);
    #1;

    // Recovery after the aborted operation.
    do_mul(64'd3, 64'd4, 64'd12, "post reset", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
